// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer.
//   op_e    : command opcodes carried on cmd_op
//   state_e : sequencer FSM states
//   SEL_*   : select codes understood by the external add/AND ALU
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_AND = 2'b01,
        OP_SUB = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_AND = 1'b1;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command / response handshake bundle for the ALU operation sequencer.
//   cmd_valid/cmd_ready : command handshake, payload cmd_op, cmd_a, cmd_b
//   rsp_valid/rsp_ready : response handshake, payload rsp_data
// master = command source / result consumer, slave = sequencer.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Initiator-side controller for the external 4-bit add/AND ALU.
// Accepts ADD/AND/SUB/MUL commands, builds SUB and MUL out of repeated ALU
// passes, and returns the result on a valid/ready response channel.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   bus (slave)     : command and response handshakes
//   busy            : high whenever the FSM is not in IDLE
//   alu_a/b/sel     : drive the external ALU
//   alu_c           : combinational ALU result, captured at the next edge
// Every output is a register or a decode of registered state only.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_op_sequencer_if.slave     bus,
    output logic                  busy,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic                  alu_sel,
    input  logic [WIDTH-1:0]      alu_c
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_reg;
    op_e              op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] rsp_data_reg;

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.rsp_valid = (state_reg == DONE);
    assign bus.rsp_data  = rsp_data_reg;
    assign busy          = (state_reg != IDLE);

    // ALU operand decode. Zero everywhere outside EXEC so the ALU sees a
    // quiet bus while idle or while a result is waiting.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = SEL_ADD;
        if (state_reg == EXEC) begin
            unique case (op_reg)
                OP_ADD: begin
                    alu_a = a_reg;
                    alu_b = b_reg;
                end
                OP_AND: begin
                    alu_a   = a_reg;
                    alu_b   = b_reg;
                    alu_sel = SEL_AND;
                end
                OP_SUB: begin
                    // Pass 0 forms -b = ~b + 1, pass 1 adds a to it.
                    if (cnt_reg == '0) begin
                        alu_a = ~b_reg;
                        alu_b = ONE;
                    end else begin
                        alu_a = a_reg;
                        alu_b = acc_reg;
                    end
                end
                OP_MUL: begin
                    // Repeated addition of a into the accumulator, b times.
                    if (b_reg != '0) begin
                        alu_a = acc_reg;
                        alu_b = a_reg;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            op_reg       <= OP_ADD;
            a_reg        <= '0;
            b_reg        <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            rsp_data_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_reg    <= op_e'(bus.cmd_op);
                        a_reg     <= bus.cmd_a;
                        b_reg     <= bus.cmd_b;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    unique case (op_reg)
                        OP_ADD, OP_AND: begin
                            rsp_data_reg <= alu_c;
                            state_reg    <= DONE;
                        end
                        OP_SUB: begin
                            if (cnt_reg == '0) begin
                                acc_reg <= alu_c;
                                cnt_reg <= ONE;
                            end else begin
                                rsp_data_reg <= alu_c;
                                state_reg    <= DONE;
                            end
                        end
                        OP_MUL: begin
                            if (b_reg == '0) begin
                                rsp_data_reg <= '0;
                                state_reg    <= DONE;
                            end else begin
                                acc_reg <= alu_c;
                                cnt_reg <= cnt_reg + ONE;
                                // cnt counts completed passes; this is the b-th.
                                if (cnt_reg + ONE == b_reg) begin
                                    rsp_data_reg <= alu_c;
                                    state_reg    <= DONE;
                                end
                            end
                        end
                    endcase
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side controller for the team's 4-bit combinational add/AND ALU (sel 0 = a+b, sel 1 = a&b).
- Accepts operation commands over a valid/ready handshake.
- Drives the ALU operand and select lines, capturing the ALU result every cycle.
- Builds multi-pass operations (SUB, MUL) from repeated ALU passes, then returns the result over a valid/ready response channel.
- Sits between a command source (testbench or future control unit) and the existing ALU, which stays external.

Parameters:
WIDTH, 4, operand, ALU and result width; all arithmetic is modulo 2^WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00 ADD, 01 AND, 10 SUB, 11 MUL
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_data  output  WIDTH  result
busy  output  1  high in any state other than IDLE
alu_a  output  WIDTH  to ALU input a
alu_b  output  WIDTH  to ALU input b
alu_sel  output  1  to ALU select (0 add, 1 and)
alu_c  input  WIDTH  from ALU output c (combinational, same cycle)

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n low at a rising edge):
  - state IDLE.
  - cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0.
  - alu_a=0, alu_b=0, alu_sel=0.
  - internal op, a, b, acc, cnt all 0.
  - Reset mid-operation aborts immediately; no response is produced.
- States: IDLE, EXEC, DONE. All outputs are registered or decoded from registered state only; no combinational path from cmd_* or rsp_ready to any output.
- IDLE:
  - cmd_ready=1, ALU outputs 0.
  - Accept occurs when cmd_valid & cmd_ready at a rising edge: latch op/a/b, clear acc and cnt, go to EXEC.
- EXEC (cmd_ready=0). Each cycle drives the ALU and captures alu_c at the next edge.
  - ADD: alu_a=a, alu_b=b, sel=0. Result=alu_c. 1 cycle.
  - AND: alu_a=a, alu_b=b, sel=1. Result=alu_c. 1 cycle.
  - SUB: pass 0 drives alu_a=~b, alu_b=1, sel=0, and acc<=alu_c. Pass 1 drives alu_a=a, alu_b=acc, sel=0; result=alu_c. 2 cycles.
  - MUL, b==0: ALU outputs 0, result=0. 1 cycle.
  - MUL, b!=0: each cycle alu_a=acc, alu_b=a, sel=0, acc<=alu_c, cnt<=cnt+1. The last pass is when cnt==b-1; result=alu_c. b cycles (max 2^WIDTH-1).
- Transition to DONE: after the last pass, rsp_data<=result and the state moves to DONE.
- Latency: rsp_valid is high N cycles after the accept edge, where N = 1 (ADD, AND), 2 (SUB), max(1, b) (MUL).
- DONE:
  - rsp_valid=1, rsp_data held stable; cmd_ready=0; ALU outputs 0.
  - On rsp_ready at an edge, go to IDLE with rsp_valid=0.
  - No new command is accepted in the same cycle as a response handoff. The minimum command-to-command spacing is therefore N+2 cycles.
- Width rules: all sums wrap modulo 2^WIDTH and the carry is discarded. SUB is two's complement, so the result wraps for a<b.
- cmd_* values are ignored while cmd_ready=0. rsp_ready is ignored outside DONE.

Decomposition:
- Shared package alu_seq_pkg:
  - op enum: OP_ADD=2'b00, OP_AND=2'b01, OP_SUB=2'b10, OP_MUL=2'b11.
  - state enum: IDLE, EXEC, DONE.
  - ALU select constants: SEL_ADD=0, SEL_AND=1.
- Single module; no sub-module needed. The ALU stays external and is connected by the parent/testbench.
- The bench pairs this block with the team ALU and a reference model in the test harness.

Test Plan:
- ADD a=9,b=8 -> rsp_data=0x1 (wrap), rsp_valid 1 cycle after accept; alu_sel=0 during EXEC.
- AND a=0xC,b=0xA -> rsp_data=0x8, latency 1; SUB a=3,b=5 -> pass 0 alu_a=0xA,alu_b=1; rsp_data=0xE, latency 2.
- MUL a=7,b=3 -> acc 7,14,5; rsp_data=0x5, latency 3. MUL a=5,b=0 -> rsp_data=0, latency 1. MUL a=1,b=15 -> rsp_data=0xF, latency 15.
- Backpressure: hold rsp_ready=0 for 4 cycles after ADD 2+3 -> rsp_data=5 stable, rsp_valid=1, cmd_ready=0. A cmd_valid asserted during DONE is not accepted until after the handoff.
- Reset mid-MUL (a=3,b=10, rst_n low at pass 4) -> next edge: IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, ALU outputs 0. A following ADD 1+1 -> 2.
- Back-to-back random ops (500, rsp_ready random) -> every result matches the modulo-16 model, in order, with no drops or duplicates.
